// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, error codes,
// and the instruction word width also used by the fetch/decode side.
package program_loader_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DAT_HI,
        DAT_LO,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus instruction-memory write port. The loader is the master;
// the host/memory side uses the slave view.
interface program_loader_if #(
    parameter int ADDR_W = 12
);
    import program_loader_pkg::*;

    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                byte_ready;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Pairs high/low bytes into instruction words, issuing a one-cycle write strobe
// with the registered address/data and tracking how many words have been written.
module loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                hi_load,
    input  logic                lo_load,
    input  logic [7:0]          byte_data,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic [ADDR_W:0]     word_count
);

    logic [7:0]         hi_q, hi_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W:0]    count_q, count_d;

    // The running word count doubles as the index of the next word to write.
    always_comb begin
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        if (clear) begin
            addr_d  = '0;
            count_d = '0;
        end else begin
            if (hi_load) begin
                hi_d = byte_data;
            end
            if (lo_load) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = {hi_q, byte_data};
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;

endmodule

// File: rtl/program_loader.sv
// Frame parser that loads instruction memory from a host byte stream and holds
// the CPU until the load finishes with a verified checksum or an error.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    program_loader_if.master  bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    loader_state_t state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [1:0]    err_q, err_d;

    logic          xfer;
    logic          start_ok;
    logic          hi_load;
    logic          lo_load;
    logic          last_word;
    logic [15:0]   len_new;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_new   = {len_q[15:8], bus.byte_data};
    assign last_word = (17'(word_count) + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    // Length is range-checked before any data byte, so the address never wraps.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        err_d   = err_q;
        if (start_ok) begin
            state_d = LEN_HI;
            sum_d   = '0;
            err_d   = ERR_NONE;
        end else if (xfer) begin
            unique case (state_q)
                LEN_HI: begin
                    len_d   = {bus.byte_data, 8'h00};
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d = len_new;
                    if (len_new == 16'd0) begin
                        state_d = CHK;
                    end else if ({1'b0, len_new} > MAX_LEN) begin
                        state_d = ERR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
                DAT_HI: begin
                    sum_d   = sum_q + bus.byte_data;
                    state_d = DAT_LO;
                end
                DAT_LO: begin
                    sum_d   = sum_q + bus.byte_data;
                    state_d = last_word ? CHK : DAT_HI;
                end
                CHK: begin
                    if (bus.byte_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_CHK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy           = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DAT_HI) ||
                         (state_q == DAT_LO) || (state_q == CHK);
        bus.byte_ready = busy;
        cpu_hold       = busy;
        done           = (state_q == DONE);
        error          = (state_q == ERR);
        error_code     = err_q;
        xfer           = bus.byte_valid && busy;
        hi_load        = xfer && (state_q == DAT_HI);
        lo_load        = xfer && (state_q == DAT_LO);
    end

    loader_word_assembler #(
        .ADDR_W (ADDR_W)
    ) u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .hi_load    (hi_load),
        .lo_load    (lo_load),
        .byte_data  (bus.byte_data),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata),
        .word_count (word_count)
    );

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame stimulus for program_loader, checked every cycle against a
// byte-count based frame model, plus literal expectations for the directed frames.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        error_code;
    logic [ADDR_W:0]   word_count;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .error_code (error_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  frameQ[$];

    // Frame model: 0 idle, 1 loading, 2 done, 3 error
    int          mMode = 0;
    logic [7:0]  mBytes[$];
    int          mWc = 0;
    int          mCode = 0;
    bit          mPend = 1'b0;
    int          mPendAddr = 0;
    int          mPendData = 0;
    int          weCount = 0;
    logic [15:0] mem [0:4095];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the model across the coming clock edge from the bytes accepted so far.
    task automatic modelStep();
        int k;
        int n;
        int s;
        mPend = 1'b0;
        if (start && mMode != 1) begin
            mMode = 1;
            mBytes.delete();
            mWc   = 0;
            mCode = 0;
        end else if (mMode == 1 && bus.byte_valid) begin
            mBytes.push_back(bus.byte_data);
            k = mBytes.size();
            n = (k >= 2) ? int'({mBytes[0], mBytes[1]}) : 0;
            if (k == 2) begin
                if (n > (1 << ADDR_W)) begin
                    mMode = 3;
                    mCode = 1;
                end
            end else if (k > 2 && k <= 2 + 2 * n) begin
                if (k % 2 == 0) begin
                    mPend     = 1'b1;
                    mPendAddr = (k - 2) / 2 - 1;
                    mPendData = int'({mBytes[k-2], mBytes[k-1]});
                    mWc++;
                end
            end else if (k > 2) begin
                s = 0;
                for (int i = 2; i < k - 1; i++) s += int'(mBytes[i]);
                if ((s % 256) == int'(mBytes[k-1])) begin
                    mMode = 2;
                end else begin
                    mMode = 3;
                    mCode = 2;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mMode = 0;
            mBytes.delete();
            mWc   = 0;
            mCode = 0;
            mPend = 1'b0;
        end
        checkOutput("busy",       32'(busy),           32'(mMode == 1));
        checkOutput("cpu_hold",   32'(cpu_hold),       32'(mMode == 1));
        checkOutput("byte_ready", 32'(bus.byte_ready), 32'(mMode == 1));
        checkOutput("done",       32'(done),           32'(mMode == 2));
        checkOutput("error",      32'(error),          32'(mMode == 3));
        checkOutput("error_code", 32'(error_code),     32'(mCode));
        checkOutput("word_count", 32'(word_count),     32'(mWc));
        checkOutput("imem_we",    32'(bus.imem_we),    32'(mPend));
        if (mPend) begin
            checkOutput("imem_addr",  32'(bus.imem_addr),  32'(mPendAddr));
            checkOutput("imem_wdata", 32'(bus.imem_wdata), 32'(mPendData));
        end
        if (!rst_n) begin
            checkOutput("reset_addr",  32'(bus.imem_addr),  32'd0);
            checkOutput("reset_wdata", 32'(bus.imem_wdata), 32'd0);
        end
        if (bus.imem_we === 1'b1) begin
            mem[bus.imem_addr] = bus.imem_wdata;
            weCount++;
        end
        if (rst_n) modelStep();
    end

    // validMode < 0 toggles byte_valid every cycle; otherwise it is a percentage.
    task automatic applyStimulus(input int validMode, input int startAt);
        int idx = 0;
        int cycles = 0;
        bit xfer;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < frameQ.size() && cycles < 20000) begin
            if (validMode < 0) bus.byte_valid = (cycles % 2 == 0);
            else               bus.byte_valid = ($urandom_range(99) < validMode);
            bus.byte_data = bus.byte_valid ? frameQ[idx] : 8'($urandom);
            start = (cycles == startAt);
            @(negedge clk);
            xfer = bus.byte_valid && bus.byte_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            cycles++;
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        start = 1'b0;
        checkOutput("frame_consumed", 32'(idx), 32'(frameQ.size()));
        @(posedge clk); #1;
    endtask

    task automatic buildFrame(input int n, input bit goodChk);
        logic [7:0] s;
        logic [7:0] b;
        frameQ.delete();
        frameQ.push_back(8'(n >> 8));
        frameQ.push_back(8'(n));
        s = 8'h00;
        if (n <= (1 << ADDR_W)) begin
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom);
                s = s + b;
                frameQ.push_back(b);
            end
            frameQ.push_back(goodChk ? s : 8'(s + 8'($urandom_range(1, 255))));
        end
    endtask

    task automatic checkNormalResult(input int wesBefore);
        checkOutput("normal_mem0",   32'(mem[0]), 32'h0000_C123);
        checkOutput("normal_mem1",   32'(mem[1]), 32'h0000_8005);
        checkOutput("normal_writes", 32'(weCount - wesBefore), 32'd2);
        checkOutput("normal_done",   32'(done), 32'd1);
        checkOutput("normal_error",  32'(error), 32'd0);
        checkOutput("normal_count",  32'(word_count), 32'd2);
        checkOutput("normal_hold",   32'(cpu_hold), 32'd0);
    endtask

    initial begin
        int wes;
        int n;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("rst_done",  32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_count", 32'(word_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] normal load");
        frameQ = '{8'h00, 8'h02, 8'hC1, 8'h23, 8'h80, 8'h05, 8'h69};
        mem[0] = 16'h0; mem[1] = 16'h0;
        wes = weCount;
        applyStimulus(100, -1);
        checkNormalResult(wes);

        $display("[TB] bad checksum");
        frameQ = '{8'h00, 8'h02, 8'hC1, 8'h23, 8'h80, 8'h05, 8'h6A};
        wes = weCount;
        applyStimulus(100, -1);
        checkOutput("badchk_writes", 32'(weCount - wes), 32'd2);
        checkOutput("badchk_error",  32'(error), 32'd1);
        checkOutput("badchk_code",   32'(error_code), 32'd2);
        checkOutput("badchk_done",   32'(done), 32'd0);

        $display("[TB] length overflow");
        frameQ = '{8'h10, 8'h01};
        wes = weCount;
        applyStimulus(100, -1);
        checkOutput("ovf_error", 32'(error), 32'd1);
        checkOutput("ovf_code",  32'(error_code), 32'd1);
        checkOutput("ovf_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("ovf_writes", 32'(weCount - wes), 32'd0);

        $display("[TB] empty frame");
        frameQ = '{8'h00, 8'h00, 8'h00};
        wes = weCount;
        applyStimulus(100, -1);
        checkOutput("empty_done",   32'(done), 32'd1);
        checkOutput("empty_count",  32'(word_count), 32'd0);
        checkOutput("empty_writes", 32'(weCount - wes), 32'd0);

        $display("[TB] throttled host with ignored start");
        frameQ = '{8'h00, 8'h02, 8'hC1, 8'h23, 8'h80, 8'h05, 8'h69};
        mem[0] = 16'h0; mem[1] = 16'h0;
        wes = weCount;
        applyStimulus(-1, 3);
        checkNormalResult(wes);

        $display("[TB] reset mid-frame");
        frameQ = '{8'h00, 8'h02, 8'hC1};
        applyStimulus(100, -1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",  32'(busy), 32'd0);
        checkOutput("midrst_hold",  32'(cpu_hold), 32'd0);
        checkOutput("midrst_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("midrst_done",  32'(done), 32'd0);
        checkOutput("midrst_error", 32'(error), 32'd0);
        checkOutput("midrst_code",  32'(error_code), 32'd0);
        checkOutput("midrst_count", 32'(word_count), 32'd0);
        checkOutput("midrst_we",    32'(bus.imem_we), 32'd0);
        checkOutput("midrst_wdata", 32'(bus.imem_wdata), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        frameQ = '{8'h00, 8'h02, 8'hC1, 8'h23, 8'h80, 8'h05, 8'h69};
        mem[0] = 16'h0; mem[1] = 16'h0;
        wes = weCount;
        applyStimulus(100, -1);
        checkNormalResult(wes);

        $display("[TB] maximum length frame");
        buildFrame(1 << ADDR_W, 1'b1);
        applyStimulus(100, -1);
        checkOutput("max_done",  32'(done), 32'd1);
        checkOutput("max_count", 32'(word_count), 32'd4096);

        $display("[TB] randomized frames");
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(9))
                0:       n = 4097 + int'($urandom_range(61438));
                1:       n = 0;
                default: n = int'($urandom_range(1, 8));
            endcase
            buildFrame(n, $urandom_range(99) < 70);
            applyStimulus(int'($urandom_range(30, 100)),
                          ($urandom_range(3) == 0) ? int'($urandom_range(1, 10)) : -1);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory path. It receives a framed byte stream from a host link and assembles 16-bit instruction words.
- It writes those words into instruction memory. The fetch stage and instruction decoder later read the same memory.
- While loading, it holds the CPU. On completion it reports success or the failure cause.

Parameters:
- ADDR_W, 12, instruction-memory address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data, {high byte, low byte}.
- cpu_hold  out  1  stalls the processor; equals busy.
- busy  out  1  load in progress.
- done  out  1  load completed with a good checksum; sticky until next start.
- error  out  1  load failed; sticky until next start.
- error_code  out  2  01 = length overflow, 10 = checksum mismatch, 00 = none.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Frame format: LEN_HI, LEN_LO (N, big-endian 16-bit), then N words, each sent high byte then low byte, then CHK. CHK = 8-bit sum mod 256 of all data bytes; length bytes are excluded.
- A byte transfers only on a cycle where byte_valid & byte_ready. byte_ready is combinational from state: 1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK; 0 otherwise. It does not depend on byte_valid.
- FSM transitions:
  - IDLE -start-> LEN_HI.
  - LEN_HI -xfer-> LEN_LO.
  - LEN_LO -xfer-> DAT_HI if 0 < N <= 2^ADDR_W; CHK if N == 0; ERR with code 01 if N > 2^ADDR_W.
  - DAT_HI -xfer-> DAT_LO.
  - DAT_LO -xfer-> DAT_HI, or CHK when this was word N.
  - CHK -xfer-> DONE if the sum matches, else ERR with code 10.
  - DONE/ERR -start-> LEN_HI; all other cases hold state.
- Word write: a transfer in DAT_LO causes imem_we=1 on the next cycle only. imem_addr = word index (0..N-1) and imem_wdata = {hi, lo} are registered together. word_count increments in that same cycle. No backpressure from memory; the next byte may transfer in that cycle.
- Address: starts at 0 on each start and increments after each write. It never wraps, because length is checked before any write.
- Sum register: cleared on start, accumulates each DAT_HI/DAT_LO byte, and is compared against CHK.
- busy=1 in LEN_HI..CHK, including the cycle of the final imem_we. cpu_hold=busy.
- done=1 only in DONE. error=1 only in ERR. error_code is held in ERR and cleared on start.
- start while busy is ignored.
- Words already written before a checksum failure stay in memory; error tells the system not to release execution.
- Reset (asynchronous, any time, including mid-frame): state=IDLE; byte_ready=imem_we=busy=cpu_hold=done=error=0; error_code=0; word_count=0; imem_addr=0; imem_wdata=0; sum=0. Partially written memory is not cleared.
- Latency: done or error rises the cycle after the CHK transfer. An overflow error rises the cycle after the LEN_LO transfer.

Decomposition:
- Shared package: FSM state encoding (IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE, ERR) and error_code constants (ERR_NONE, ERR_LEN, ERR_CHK).
- Shared package: instruction word width constant 16, shared with decoder-side modules.
- One natural sub-module: loader_word_assembler. It latches the high byte, produces the registered {hi,lo} word with a one-cycle write pulse, and holds the address/word counter.

Test Plan:
- Normal load: start; bytes 00 02 C1 23 80 05 69 with byte_valid held high. Expect imem_we at addr 0 with C123, then addr 1 with 8005; done=1; error=0; word_count=2; cpu_hold falls with done.
- Bad checksum: same frame with CHK=6A. Expect both writes to occur, then error=1, error_code=10, done=0.
- Length overflow (ADDR_W=12): bytes 10 01. Expect ERR the cycle after LEN_LO, error_code=01, byte_ready=0, no imem_we.
- Empty frame: 00 00 00. Expect done=1, word_count=0, no imem_we.
- Throttled host and ignored start: byte_valid toggled 1/0 every cycle on the normal frame, and start pulsed mid-frame. Expect results identical to the normal load, with the start ignored.
- Reset mid-frame: assert rst_n=0 after 3 bytes. Expect all outputs 0 asynchronously and state IDLE. A following start plus the normal frame must then load correctly from addr 0.
